ucie_ctl_phy_sb_cfg_arbiter: RTL
================================

# ucie_ctl_phy_sb_cfg_arbiter

Shares the single PHY-to-Adapter RDI configuration channel (`o_rdi_pl_cfg_vld` / `o_rdi_pl_cfg`) between several sideband message sources, such as locally generated PHY messages and messages received from the remote link partner. The block grants sources round-robin and keeps each multi-flit message atomic. It owns the pl_cfg credit counter, which Adapter `i_rdi_lp_cfg_crd` pulses replenish, and blocks new messages when no credit remains. It sits in the PHY between the sideband message sources and the RDI cfg output.

## Interface
Parameters:
- `NC`, 32: cfg flit width in bits.
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `MAX_CRD`, 4: cfg credits advertised by the Adapter after reset; legal range 1..15.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req_vld`  in  NUM_REQ  per-requester flit valid.
- `i_req_data`  in  NUM_REQ*NC  requester flits; requester k uses bits [k*NC +: NC].
- `i_req_last`  in  NUM_REQ  flit is the final flit of its message.
- `o_req_rdy`  out  NUM_REQ  flit accepted this cycle; one-hot or zero.
- `i_rdi_lp_cfg_crd`  in  1  one-cycle pulse returning one credit.
- `o_rdi_pl_cfg_vld`  out  1  cfg flit valid to the Adapter.
- `o_rdi_pl_cfg`  out  NC  cfg flit.
- `o_crd_cnt`  out  $clog2(MAX_CRD+1)  credits currently available.
- `o_busy`  out  1  a message is in progress (state LOCKED).
- `o_crd_ovf`  out  1  sticky error flag: a credit was returned while the counter was already full.

## Operation
- One credit is consumed per message, at acceptance of its first flit. A flit is accepted when `o_req_rdy[k] & i_req_vld[k]`.
- State machine: IDLE, LOCKED.
- IDLE, credit gating:
  - If `o_crd_cnt == 0`, all `o_req_rdy` bits are 0.
  - Otherwise the round-robin arbiter picks the first valid requester at or after `rr_ptr`, and that requester's `o_req_rdy` bit is asserted combinationally in the same cycle.
- IDLE, on acceptance:
  - If the accepted flit has `i_req_last=1`, the state stays IDLE and `rr_ptr` moves to winner+1 (mod NUM_REQ).
  - If `i_req_last=0`, the block latches `grant_idx` and goes to LOCKED.
- LOCKED:
  - `o_req_rdy[grant_idx]` is held at 1; all other bits are 0.
  - Credits are not checked, because the message already paid.
  - A flit with `i_req_last=1` returns the block to IDLE and sets `rr_ptr` to grant_idx+1.
  - If the granted requester drops `i_req_vld` mid-message, a bubble is inserted: `o_rdi_pl_cfg_vld=0` that cycle. The lock is kept and no other requester is served.
- Credit counter:
  - Next value = cnt − consume + return.
  - A simultaneous consume and return leaves the count unchanged.
  - A return while cnt==MAX_CRD with no consume: the counter saturates at MAX_CRD and `o_crd_ovf` is set. `o_crd_ovf` clears only on reset.
- Reset values:
  - State IDLE, `rr_ptr` 0, `grant_idx` 0.
  - `o_crd_cnt` = MAX_CRD.
  - `o_rdi_pl_cfg_vld` 0, `o_rdi_pl_cfg` 0.
  - `o_crd_ovf` 0.
- Reset mid-message: the message is abandoned without completion and the credit is restored to MAX_CRD. Requesters must restart the message from its first flit.

## Timing
- Acceptance to output: flit accepted in cycle t appears on `o_rdi_pl_cfg` with `o_rdi_pl_cfg_vld=1` in cycle t+1 (registered output).
- `o_rdi_pl_cfg` is 0 whenever `o_rdi_pl_cfg_vld` is 0.
- Back-to-back messages: a single-flit message from requester A in cycle t and a message from requester B in cycle t+1 is legal. This gives zero idle cycles between messages, provided credits are available.
- A credit returned in cycle t is usable for arbitration in cycle t+1. `o_crd_cnt` is registered.
- `o_busy` is high in every cycle the state register holds LOCKED.

## Structure
- Shared package `ucie_ctl_phy_pkg` holds:
  - the `sb_cfg_arb_states_e` enum {IDLE=1'b0, LOCKED=1'b1};
  - the default NC constant.
- Sub-module `ucie_ctl_rr_arbiter`:
  - parameter NUM_REQ;
  - inputs: request vector, `rr_ptr`, enable;
  - output: one-hot grant, combinational.
- Credit counter, FSM and output register live in the top module.

## Test plan
- Reset release, then requester 0 sends a single flit 32'hA5A5_0001 with last=1. Required: rdy0=1 in the same cycle; `o_rdi_pl_cfg_vld=1` and `o_rdi_pl_cfg=32'hA5A5_0001` one cycle later; `o_crd_cnt` goes 4→3.
- Both requesters hold valid 3-flit messages. Required: requester 0's three flits are output contiguously, then requester 1's three flits, with no interleave. `rr_ptr` ends at 0, and `o_crd_cnt`=2.
- Drain credits with 4 single-flit messages and no returns. A fifth request is held with rdy=0 for 10 cycles. Required: after one `i_rdi_lp_cfg_crd` pulse, it is accepted on the next cycle.
- With `o_crd_cnt`=1, pulse `i_rdi_lp_cfg_crd` in the same cycle a first flit is accepted. Required: `o_crd_cnt` stays 1.
- With `o_crd_cnt`=4, pulse `i_rdi_lp_cfg_crd`. Required: count stays 4 and `o_crd_ovf`=1 until reset.
- Requester 1 drops valid for 2 cycles mid-message while requester 0 is valid. Required: 2 bubble cycles, requester 0 not served until requester 1's last flit; then assert `i_rst_n`=0 mid-message and check all reset values.

Source files
------------

// File: rtl/ucie_ctl_phy_pkg.sv
// Shared PHY control types: sideband cfg arbiter state encoding and default flit width.
package ucie_ctl_phy_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sb_cfg_arb_states_e;

  localparam int SB_CFG_NC = 32;

endpackage

// File: rtl/ucie_ctl_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request at or after rr_ptr.
module ucie_ctl_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap rr_ptr + i back into 0..NUM_REQ-1 without a modulo operator.
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_phy_sb_cfg_arbiter.sv
// Shares the RDI pl_cfg channel between sideband sources: round-robin, atomic
// multi-flit messages, one pl_cfg credit consumed per message.
module ucie_ctl_phy_sb_cfg_arbiter
  import ucie_ctl_phy_pkg::*;
#(
  parameter int NC      = SB_CFG_NC,
  parameter int NUM_REQ = 2,
  parameter int MAX_CRD = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_vld,
  input  logic [NUM_REQ*NC-1:0]        i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  input  logic                         i_rdi_lp_cfg_crd,
  output logic                         o_rdi_pl_cfg_vld,
  output logic [NC-1:0]                o_rdi_pl_cfg,
  output logic [$clog2(MAX_CRD+1)-1:0] o_crd_cnt,
  output logic                         o_busy,
  output logic                         o_crd_ovf
);

  // Handshake: a flit moves when o_req_rdy[k] & i_req_vld[k]; rdy never depends on
  // anything but state, credits, rr_ptr and the valid vector, so sources may hold
  // valid with stable data/last until they see rdy.

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_CRD + 1);

  sb_cfg_arb_states_e state_q, state_d;

  logic [PW-1:0]      rr_ptr_q, grant_idx_q, acc_idx, next_ptr;
  logic [NUM_REQ-1:0] arb_gnt, acc_vec;
  logic               arb_en, accept, acc_last, consume;
  logic [NC-1:0]      acc_data;
  logic [CW-1:0]      crd_q;
  logic               ovf_q;

  assign arb_en = (state_q == IDLE) && (crd_q != '0);

  ucie_ctl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (i_req_vld),
    .rr_ptr (rr_ptr_q),
    .en     (arb_en),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !acc_last) state_d = LOCKED;
      LOCKED:  if (accept && acc_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_rdy = '0;
    o_busy    = 1'b0;
    case (state_q)
      IDLE:   o_req_rdy = arb_gnt;
      LOCKED: begin
        o_req_rdy[grant_idx_q] = 1'b1;
        o_busy                 = 1'b1;
      end
      default: o_req_rdy = '0;
    endcase
  end

  // Accepted-flit decode; o_req_rdy is one-hot so at most one term contributes.
  always_comb begin
    acc_vec  = o_req_rdy & i_req_vld;
    accept   = |acc_vec;
    acc_idx  = '0;
    acc_data = '0;
    acc_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc_vec[k]) begin
        acc_idx  = PW'(k);
        acc_data = i_req_data[k*NC +: NC];
        acc_last = i_req_last[k];
      end
    end
  end

  assign consume  = accept && (state_q == IDLE);
  assign next_ptr = (acc_idx == PW'(NUM_REQ - 1)) ? '0 : acc_idx + PW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_q         <= '0;
      grant_idx_q      <= '0;
      o_rdi_pl_cfg_vld <= 1'b0;
      o_rdi_pl_cfg     <= '0;
      crd_q            <= CW'(MAX_CRD);
      ovf_q            <= 1'b0;
    end else begin
      if (accept && acc_last)   rr_ptr_q    <= next_ptr;
      if (consume && !acc_last) grant_idx_q <= acc_idx;
      o_rdi_pl_cfg_vld <= accept;
      o_rdi_pl_cfg     <= accept ? acc_data : '0;
      if (consume && !i_rdi_lp_cfg_crd) begin
        crd_q <= crd_q - CW'(1);
      end else if (!consume && i_rdi_lp_cfg_crd) begin
        // A return beyond what the Adapter advertised is a protocol error: saturate and flag.
        if (crd_q == CW'(MAX_CRD)) ovf_q <= 1'b1;
        else                       crd_q <= crd_q + CW'(1);
      end
    end
  end

  assign o_crd_cnt = crd_q;
  assign o_crd_ovf = ovf_q;

endmodule
